// File: rtl/dcache_sched_pkg.sv
// Shared encodings for the data-cache port scheduler: source ids, FSM states
// and the access-size to byte-count table.
package dcache_sched_pkg;

  localparam int NUM_SRC = 3;

  localparam logic [1:0] SRC_WB = 2'd0;
  localparam logic [1:0] SRC_RD = 2'd1;
  localparam logic [1:0] SRC_SW = 2'd2;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SPLIT2 = 1'b1
  } state_e;

  // Indexed by the 2-bit size code: 1B, 2B, 4B, 8B.
  localparam logic [3:0] SIZE_BYTES [4] = '{4'd1, 4'd2, 4'd4, 4'd8};

endpackage

// File: rtl/dcache_age_arb.sv
// Per-requester wait-age counters and winner select. Requesters that have
// waited AGE_MAX cycles beat the fixed WB > RD > SW order; grant is one-hot.
module dcache_age_arb
  import dcache_sched_pkg::*;
#(
  parameter int AGE_MAX = 7,
  parameter int AGE_W   = 3
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [NUM_SRC-1:0] req_valid,
  input  logic [NUM_SRC-1:0] req_ack,
  output logic [NUM_SRC-1:0] grant
`ifdef DCPS_PERF_CNT_EN
  ,
  output logic               promoted
`endif
);

  localparam logic [AGE_W-1:0] AGE_SAT = AGE_W'(AGE_MAX);
  localparam logic [AGE_W-1:0] AGE_ONE = AGE_W'(1);
  localparam logic [NUM_SRC-1:0] VEC_ONE = NUM_SRC'(1);

  logic [NUM_SRC-1:0] old_vec;
  logic [NUM_SRC-1:0] fixed_pick;
  logic [NUM_SRC-1:0] promo_pick;

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_age
      logic [AGE_W-1:0] age_q;
      logic [AGE_W-1:0] age_d;

      assign old_vec[gi] = req_valid[gi] && (age_q == AGE_SAT);

      always_comb begin
        age_d = age_q;
        if (!req_valid[gi] || req_ack[gi]) begin
          age_d = '0;
        end else if (age_q != AGE_SAT) begin
          age_d = age_q + AGE_ONE;
        end
      end

      always_ff @(posedge clk) begin
        if (!clr) begin
          age_q <= '0;
        end else begin
          age_q <= age_d;
        end
      end
    end
  endgenerate

  // Lowest set bit of each candidate vector gives the priority pick.
  assign fixed_pick = req_valid & ~(req_valid - VEC_ONE);
  assign promo_pick = old_vec & ~(old_vec - VEC_ONE);
  assign grant      = (|old_vec) ? promo_pick : fixed_pick;

`ifdef DCPS_PERF_CNT_EN
  assign promoted = (|old_vec) && (promo_pick != fixed_pick);
`endif

endmodule

// File: rtl/dcache_port_sched.sv
// Single-slot scheduler in front of the D-cache pipeline: arbitrates WB/RD/SW,
// splits line-crossing accesses into two beats. Optional counters: DCPS_PERF_CNT_EN.
module dcache_port_sched
  import dcache_sched_pkg::*;
#(
  parameter int AGE_MAX    = 7,
  parameter int AGE_W      = 3,
  parameter int LINE_OFS_W = 4
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        wb_valid,
  input  logic        rd_valid,
  input  logic        sw_valid,
  output logic        wb_ready,
  output logic        rd_ready,
  output logic        sw_ready,
  input  logic [31:0] wb_addr,
  input  logic [31:0] rd_addr,
  input  logic [31:0] sw_addr,
  input  logic [1:0]  wb_size,
  input  logic [1:0]  rd_size,
  input  logic [1:0]  sw_size,
  input  logic [6:0]  wb_ptcid,
  input  logic [6:0]  rd_ptcid,
  input  logic [6:0]  sw_ptcid,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_addr,
  output logic [1:0]  out_size,
  output logic [6:0]  out_ptcid,
  output logic [1:0]  out_src,
  output logic        out_beat,
  output logic        out_last,
  output logic        busy
`ifdef DCPS_PERF_CNT_EN
  ,
  output logic [31:0] perf_grants_wb,
  output logic [31:0] perf_grants_rd,
  output logic [31:0] perf_grants_sw,
  output logic [31:0] perf_splits,
  output logic [31:0] perf_promotions
`endif
);

  localparam int SPAN_W = LINE_OFS_W + 1;
  localparam int LINE_W = 32 - LINE_OFS_W;
  localparam logic [SPAN_W-1:0] SPAN_ONE = SPAN_W'(1);
  localparam logic [LINE_W-1:0] LINE_ONE = LINE_W'(1);

  state_e              state_q;
  logic                out_valid_q;
  logic [31:0]         out_addr_q;
  logic [1:0]          out_size_q;
  logic [6:0]          out_ptcid_q;
  logic [1:0]          out_src_q;
  logic                out_beat_q;
  logic                out_last_q;
  logic [LINE_W-1:0]   cap_line_q;
  logic [1:0]          cap_src_q;

  logic [NUM_SRC-1:0]  req_valid;
  logic [NUM_SRC-1:0]  grant;
  logic [NUM_SRC-1:0]  ready_vec;
  logic [31:0]         sel_addr;
  logic [1:0]          sel_size;
  logic [6:0]          sel_ptcid;
  logic [1:0]          sel_src;
  logic [SPAN_W-1:0]   span;
  logic                split_sel;
  logic                reg_free;
  logic                load_first;
  logic                load_second;

  assign req_valid = {sw_valid, rd_valid, wb_valid};
  assign reg_free  = !out_valid_q || out_ready;

`ifdef DCPS_PERF_CNT_EN
  logic promoted;
`endif

  dcache_age_arb #(
    .AGE_MAX (AGE_MAX),
    .AGE_W   (AGE_W)
  ) u_age_arb (
    .clk       (clk),
    .clr       (clr),
    .req_valid (req_valid),
    .req_ack   (ready_vec),
    .grant     (grant)
`ifdef DCPS_PERF_CNT_EN
    ,
    .promoted  (promoted)
`endif
  );

  always_comb begin
    sel_addr  = wb_addr;
    sel_size  = wb_size;
    sel_ptcid = wb_ptcid;
    sel_src   = SRC_WB;
    if (grant[1]) begin
      sel_addr  = rd_addr;
      sel_size  = rd_size;
      sel_ptcid = rd_ptcid;
      sel_src   = SRC_RD;
    end else if (grant[2]) begin
      sel_addr  = sw_addr;
      sel_size  = sw_size;
      sel_ptcid = sw_ptcid;
      sel_src   = SRC_SW;
    end
  end

  assign span      = {1'b0, sel_addr[LINE_OFS_W-1:0]} + SPAN_W'(SIZE_BYTES[sel_size]) - SPAN_ONE;
  assign split_sel = span[LINE_OFS_W];

  assign load_first  = clr && (state_q == ST_IDLE) && reg_free && (|grant);
  assign load_second = clr && (state_q == ST_SPLIT2) && reg_free;

  // A split access is only acknowledged when its second beat is loaded.
  always_comb begin
    ready_vec = '0;
    if (load_first && !split_sel) begin
      ready_vec = grant;
    end else if (load_second) begin
      ready_vec = NUM_SRC'(1) << cap_src_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_size_q  <= '0;
      out_ptcid_q <= '0;
      out_src_q   <= '0;
      out_beat_q  <= 1'b0;
      out_last_q  <= 1'b0;
      cap_line_q  <= '0;
      cap_src_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (reg_free) begin
            if (|grant) begin
              out_valid_q <= 1'b1;
              out_addr_q  <= sel_addr;
              out_size_q  <= sel_size;
              out_ptcid_q <= sel_ptcid;
              out_src_q   <= sel_src;
              out_beat_q  <= 1'b0;
              out_last_q  <= !split_sel;
              cap_line_q  <= sel_addr[31:LINE_OFS_W];
              cap_src_q   <= sel_src;
              if (split_sel) begin
                state_q <= ST_SPLIT2;
              end
            end else begin
              out_valid_q <= 1'b0;
            end
          end
        end
        ST_SPLIT2: begin
          // size/ptcid/src registers still hold the first beat's values.
          if (reg_free) begin
            out_valid_q <= 1'b1;
            out_addr_q  <= {cap_line_q + LINE_ONE, {LINE_OFS_W{1'b0}}};
            out_beat_q  <= 1'b1;
            out_last_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign wb_ready  = ready_vec[0];
  assign rd_ready  = ready_vec[1];
  assign sw_ready  = ready_vec[2];
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_size  = out_size_q;
  assign out_ptcid = out_ptcid_q;
  assign out_src   = out_src_q;
  assign out_beat  = out_beat_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != ST_IDLE) || out_valid_q;

`ifdef DCPS_PERF_CNT_EN
  logic [31:0] perf_wb_q, perf_rd_q, perf_sw_q, perf_split_q, perf_promo_q;

  always_ff @(posedge clk) begin
    if (!clr) begin
      perf_wb_q    <= '0;
      perf_rd_q    <= '0;
      perf_sw_q    <= '0;
      perf_split_q <= '0;
      perf_promo_q <= '0;
    end else begin
      if (ready_vec[0]) perf_wb_q <= perf_wb_q + 32'd1;
      if (ready_vec[1]) perf_rd_q <= perf_rd_q + 32'd1;
      if (ready_vec[2]) perf_sw_q <= perf_sw_q + 32'd1;
      if (load_first && split_sel) perf_split_q <= perf_split_q + 32'd1;
      if (load_first && promoted) perf_promo_q <= perf_promo_q + 32'd1;
    end
  end

  assign perf_grants_wb  = perf_wb_q;
  assign perf_grants_rd  = perf_rd_q;
  assign perf_grants_sw  = perf_sw_q;
  assign perf_splits     = perf_split_q;
  assign perf_promotions = perf_promo_q;
`endif

endmodule

// File: tb/tb_dcache_port_sched.sv
// Bench for dcache_port_sched: queue-driven requesters, a cycle model built
// from the arbitration/split rules, and literal checks at key cycles.
module tb_dcache_port_sched;

  logic        clk = 1'b0;
  logic        clr;
  logic        wb_valid, rd_valid, sw_valid;
  logic        wb_ready, rd_ready, sw_ready;
  logic [31:0] wb_addr, rd_addr, sw_addr;
  logic [1:0]  wb_size, rd_size, sw_size;
  logic [6:0]  wb_ptcid, rd_ptcid, sw_ptcid;
  logic        out_valid, out_ready;
  logic [31:0] out_addr;
  logic [1:0]  out_size;
  logic [6:0]  out_ptcid;
  logic [1:0]  out_src;
  logic        out_beat, out_last, busy;
`ifdef DCPS_PERF_CNT_EN
  logic [31:0] perf_grants_wb, perf_grants_rd, perf_grants_sw, perf_splits, perf_promotions;
`endif

  always #5 clk = ~clk;

  dcache_port_sched dut (
    .clk(clk), .clr(clr),
    .wb_valid(wb_valid), .rd_valid(rd_valid), .sw_valid(sw_valid),
    .wb_ready(wb_ready), .rd_ready(rd_ready), .sw_ready(sw_ready),
    .wb_addr(wb_addr), .rd_addr(rd_addr), .sw_addr(sw_addr),
    .wb_size(wb_size), .rd_size(rd_size), .sw_size(sw_size),
    .wb_ptcid(wb_ptcid), .rd_ptcid(rd_ptcid), .sw_ptcid(sw_ptcid),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_size(out_size), .out_ptcid(out_ptcid),
    .out_src(out_src), .out_beat(out_beat), .out_last(out_last),
    .busy(busy)
`ifdef DCPS_PERF_CNT_EN
    ,
    .perf_grants_wb(perf_grants_wb), .perf_grants_rd(perf_grants_rd),
    .perf_grants_sw(perf_grants_sw), .perf_splits(perf_splits),
    .perf_promotions(perf_promotions)
`endif
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  size;
    logic [6:0]  ptcid;
  } acc_t;

  acc_t q_wb[$];
  acc_t q_rd[$];
  acc_t q_sw[$];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model state: the visible output register plus pending split and ages.
  bit          m_ov, m_beat, m_last, m_split;
  logic [31:0] m_addr, m_cap_addr;
  logic [1:0]  m_size, m_src;
  logic [6:0]  m_ptcid;
  int          m_cap_src;
  int          m_age[3];

  logic [2:0]  rdy_rec;
  int          ack_cnt[3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit crosses(input logic [31:0] a, input logic [1:0] s);
    int ofs;
    ofs = int'(a & 32'hF);
    return (ofs + (1 << s)) > 16;
  endfunction

  function automatic int pick(input logic [2:0] v);
    for (int i = 0; i < 3; i++) if (v[i] && m_age[i] == 7) return i;
    for (int i = 0; i < 3; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic acc_t req(input int i);
    case (i)
      0: return {wb_addr, wb_size, wb_ptcid};
      1: return {rd_addr, rd_size, rd_ptcid};
      default: return {sw_addr, sw_size, sw_ptcid};
    endcase
  endfunction

  task automatic drive();
    wb_valid = (q_wb.size() > 0);
    rd_valid = (q_rd.size() > 0);
    sw_valid = (q_sw.size() > 0);
    if (wb_valid) {wb_addr, wb_size, wb_ptcid} = q_wb[0];
    if (rd_valid) {rd_addr, rd_size, rd_ptcid} = q_rd[0];
    if (sw_valid) {sw_addr, sw_size, sw_ptcid} = q_sw[0];
  endtask

  task automatic model_reset();
    m_ov = 0; m_beat = 0; m_last = 0; m_split = 0;
    m_addr = '0; m_size = '0; m_ptcid = '0; m_src = '0;
    m_cap_addr = '0; m_cap_src = 0;
    for (int i = 0; i < 3; i++) m_age[i] = 0;
  endtask

  task automatic step();
    logic [2:0] v, exp_rdy, act_rdy;
    bit         free;
    int         w;
    acc_t       r;
    drive();
    @(negedge clk);
    v       = {sw_valid, rd_valid, wb_valid};
    act_rdy = {sw_ready, rd_ready, wb_ready};
    free    = !m_ov || out_ready;
    exp_rdy = '0;
    w       = -1;
    r       = '0;
    if (clr) begin
      if (m_split) begin
        if (free) exp_rdy[m_cap_src] = 1'b1;
      end else if (free) begin
        w = pick(v);
        if (w >= 0) begin
          r = req(w);
          if (!crosses(r.addr, r.size)) exp_rdy[w] = 1'b1;
        end
      end
    end
    if (chk_en) begin
      chk("ready", act_rdy, exp_rdy);
      chk("out_fields", {out_valid, out_addr, out_size, out_ptcid, out_src, out_beat, out_last},
          {m_ov, m_addr, m_size, m_ptcid, m_src, m_beat, m_last});
      chk("busy", busy, m_split || m_ov);
    end
    rdy_rec = act_rdy;
    for (int i = 0; i < 3; i++) if (act_rdy[i]) ack_cnt[i]++;
    if (!clr) begin
      model_reset();
    end else begin
      for (int i = 0; i < 3; i++)
        m_age[i] = (!v[i] || exp_rdy[i]) ? 0 : ((m_age[i] < 7) ? m_age[i] + 1 : 7);
      if (m_split) begin
        if (free) begin
          m_ov = 1; m_addr = ((m_cap_addr >> 4) + 1) << 4;
          m_beat = 1; m_last = 1; m_split = 0;
        end
      end else if (free) begin
        if (w >= 0) begin
          m_ov = 1; m_addr = r.addr; m_size = r.size; m_ptcid = r.ptcid;
          m_src = w[1:0]; m_beat = 0;
          m_split = crosses(r.addr, r.size);
          m_last = !m_split;
          m_cap_addr = r.addr; m_cap_src = w;
        end else begin
          m_ov = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    if (rdy_rec[0]) void'(q_wb.pop_front());
    if (rdy_rec[1]) void'(q_rd.pop_front());
    if (rdy_rec[2]) void'(q_sw.pop_front());
  endtask

  initial begin
    int sw_before;
    clr = 1'b0; out_ready = 1'b1;
    wb_valid = 0; rd_valid = 0; sw_valid = 0;
    wb_addr = '0; rd_addr = '0; sw_addr = '0;
    wb_size = '0; rd_size = '0; sw_size = '0;
    wb_ptcid = '0; rd_ptcid = '0; sw_ptcid = '0;
    for (int i = 0; i < 3; i++) ack_cnt[i] = 0;
    model_reset();

    // Reset: outputs all zero.
    step();
    chk_en = 1'b1;
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fields", {out_addr, out_size, out_ptcid, out_src, out_beat, out_last}, 0);
    clr = 1'b1;
    step();

    // Single read, 4B, no split.
    q_rd.push_back('{32'h0000_1004, 2'd2, 7'h11});
    step();
    chk("rd_valid_out", out_valid, 1);
    chk("rd_addr_out", out_addr, 32'h0000_1004);
    chk("rd_src_beat_last", {out_src, out_beat, out_last}, {2'd1, 1'b0, 1'b1});
    step(); step();
    chk("rd_single_ack", ack_cnt[1], 1);

    // WB and RD together: WB first, RD next.
    q_wb.push_back('{32'h0000_3000, 2'd2, 7'h05});
    q_rd.push_back('{32'h0000_3100, 2'd1, 7'h06});
    step();
    chk("wbrd_first", rdy_rec, 3'b001);
    step();
    chk("wbrd_second", rdy_rec, 3'b010);
    chk("wbrd_second_src", out_src, 2'd1);
    step();

    // SW split across a line, WB arrives mid-split and waits.
    q_sw.push_back('{32'h0000_200E, 2'd3, 7'h22});
    step();
    chk("split_b0_addr", out_addr, 32'h0000_200E);
    chk("split_b0_beat_last", {out_beat, out_last}, 2'b00);
    chk("split_b0_noack", rdy_rec, 3'b000);
    q_wb.push_back('{32'h0000_4000, 2'd0, 7'h01});
    step();
    chk("split_b1_ack", rdy_rec, 3'b100);
    chk("split_b1_addr", out_addr, 32'h0000_2010);
    chk("split_b1_beat_last", {out_beat, out_last}, 2'b11);
    step();
    chk("split_wb_after", rdy_rec, 3'b001);
    chk("split_wb_addr", out_addr, 32'h0000_4000);
    step(); step();

    // Address wrap on the second beat, and a 2B access crossing at offset 15.
    q_rd.push_back('{32'hFFFF_FFFC, 2'd3, 7'h03});
    step(); step();
    chk("wrap_addr", out_addr, 32'h0000_0000);
    chk("wrap_beat", out_beat, 1);
    q_wb.push_back('{32'h0000_500F, 2'd1, 7'h09});
    step(); step();
    chk("ofs15_b1_addr", out_addr, 32'h0000_5010);
    step(); step();

    // Starvation: SW promoted once its age reaches 7 despite WB valid.
    for (int i = 0; i < 10; i++) q_wb.push_back('{32'h0000_6000 + 32'(i * 16), 2'd2, 7'(i)});
    q_sw.push_back('{32'h0000_7000, 2'd2, 7'h40});
    for (int i = 0; i < 7; i++) begin
      step();
      chk("age_wb_first", rdy_rec, 3'b001);
    end
    step();
    chk("age_sw_promoted", rdy_rec, 3'b100);
    chk("age_sw_addr", out_addr, 32'h0000_7000);
    step();
    chk("age_wb_resume", rdy_rec, 3'b001);
    for (int i = 0; i < 6; i++) step();

    // Backpressure: fields stable, no acks while out_ready is low.
    out_ready = 1'b0;
    q_rd.push_back('{32'h0000_8004, 2'd2, 7'h12});
    step();
    chk("stall_load", rdy_rec, 3'b010);
    q_rd.push_back('{32'h0000_8008, 2'd2, 7'h13});
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_hold_addr", out_addr, 32'h0000_8004);
      chk("stall_no_ready", rdy_rec, 3'b000);
    end
    out_ready = 1'b1;
    step();
    chk("stall_release_ack", rdy_rec, 3'b010);
    chk("stall_release_addr", out_addr, 32'h0000_8008);
    step(); step();

    // Reset while a split is pending: dropped, then re-granted from beat 0.
    out_ready = 1'b0;
    q_sw.push_back('{32'h0000_200E, 2'd3, 7'h22});
    sw_before = ack_cnt[2];
    step();
    chk("rsplit_b0", {out_valid, out_beat, out_last}, 3'b100);
    clr = 1'b0;
    step();
    chk("rsplit_out_valid", out_valid, 0);
    chk("rsplit_busy", busy, 0);
    chk("rsplit_no_ack", ack_cnt[2], sw_before);
    clr = 1'b1;
    out_ready = 1'b1;
    step();
    chk("rsplit_regrant_addr", out_addr, 32'h0000_200E);
    chk("rsplit_regrant_beat", out_beat, 0);
    step();
    chk("rsplit_b1_ack", rdy_rec, 3'b100);
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
